flash_byte_streamer: RTL and testbench

Byte-stream sequencer between the flash word-read interface and the MP3 decoder input. Walks a word address range [start_word, end_word] one byte at a time, forward or reverse, with optional loop. Fetches one word at a time over a request/acknowledge handshake and presents bytes over a valid/ready handshake. It is the parametrised, stateful successor to the combinational word/byte stepper.

---
 rtl/flash_stream_pkg.sv | 16 +
 rtl/flash_byte_streamer_byte_step.sv | 59 +++++
 rtl/flash_byte_streamer.sv | 146 ++++++++++++++
 tb/tb_flash_byte_streamer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_stream_pkg.sv
// Shared types and helpers for the flash byte streamer.
package flash_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2,
    FINISH = 2'd3
  } stream_state_t;

  // Byte-index width inside one flash word.
  function automatic int idx_width(input int bytes_per_word);
    return (bytes_per_word > 1) ? $clog2(bytes_per_word) : 1;
  endfunction

endpackage

// File: rtl/flash_byte_streamer_byte_step.sv
// Combinational word/byte stepper: one byte step forward or backward inside [start, end].
module byte_step
  import flash_stream_pkg::*;
#(
  parameter int ADDR_W         = 23,
  parameter int BYTES_PER_WORD = 4,
  parameter int WORD_DELTA     = 1,
  localparam int IDX_W         = idx_width(BYTES_PER_WORD)
) (
  input  logic [ADDR_W-1:0] word_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              reverse_i,
  input  logic [ADDR_W-1:0] start_word_i,
  input  logic [ADDR_W-1:0] end_word_i,
  output logic [ADDR_W-1:0] next_word_o,
  output logic [IDX_W-1:0]  next_idx_o,
  output logic              word_changed_o,
  output logic              boundary_o
);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0] DELTA    = ADDR_W'(WORD_DELTA);

  // At a boundary the next word is the wrap target, so the caller only decides loop vs. finish.
  always_comb begin
    next_word_o    = word_i;
    next_idx_o     = idx_i;
    word_changed_o = 1'b0;
    boundary_o     = 1'b0;
    if (!reverse_i) begin
      if (idx_i == LAST_IDX) begin
        word_changed_o = 1'b1;
        next_idx_o     = '0;
        if (word_i == end_word_i) begin
          boundary_o  = 1'b1;
          next_word_o = start_word_i;
        end else begin
          next_word_o = word_i + DELTA;
        end
      end else begin
        next_idx_o = idx_i + IDX_W'(1);
      end
    end else begin
      if (idx_i == '0) begin
        word_changed_o = 1'b1;
        next_idx_o     = LAST_IDX;
        if (word_i == start_word_i) begin
          boundary_o  = 1'b1;
          next_word_o = end_word_i;
        end else begin
          next_word_o = word_i - DELTA;
        end
      end else begin
        next_idx_o = idx_i - IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/flash_byte_streamer.sv
// Byte-stream sequencer: fetches flash words over req/ack and hands out bytes over valid/ready.
module flash_byte_streamer
  import flash_stream_pkg::*;
#(
  parameter int ADDR_W         = 23,
  parameter int BYTES_PER_WORD = 4,
  parameter int WORD_DELTA     = 1,
  localparam int DATA_W        = 8 * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              reverse,
  input  logic              loop,
  input  logic [ADDR_W-1:0] start_word,
  input  logic [ADDR_W-1:0] end_word,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [7:0]        byte_data,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = idx_width(BYTES_PER_WORD);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_WORD - 1);

  stream_state_t     state_q, state_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic              abort_q, abort_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] step_word;
  logic [IDX_W-1:0]  step_idx;
  logic              step_changed;
  logic              step_boundary;

  byte_step #(
    .ADDR_W        (ADDR_W),
    .BYTES_PER_WORD(BYTES_PER_WORD),
    .WORD_DELTA    (WORD_DELTA)
  ) u_step (
    .word_i        (word_q),
    .idx_i         (idx_q),
    .reverse_i     (reverse),
    .start_word_i  (start_q),
    .end_word_i    (end_q),
    .next_word_o   (step_word),
    .next_idx_o    (step_idx),
    .word_changed_o(step_changed),
    .boundary_o    (step_boundary)
  );

  // An inverted range still spends one busy cycle in FETCH (request suppressed) so the
  // range compare stays off the start path; done then lands two cycles after start.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    start_d = start_q;
    end_d   = end_q;
    abort_d = abort_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start && !stop) begin
          start_d = start_word;
          end_d   = end_word;
          err_d   = (start_word > end_word);
          abort_d = 1'b0;
          word_d  = reverse ? end_word : start_word;
          idx_d   = reverse ? LAST_IDX : '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (err_q) begin
          state_d = FINISH;
        end else if (mem_ack) begin
          if (abort_q || stop) begin
            state_d = FINISH;
          end else begin
            buf_d   = mem_data;
            state_d = STREAM;
          end
        end else if (stop) begin
          abort_d = 1'b1;
        end
      end
      STREAM: begin
        if (stop) begin
          state_d = FINISH;
        end else if (byte_ready) begin
          if (step_boundary && !loop) begin
            state_d = FINISH;
          end else begin
            word_d = step_word;
            idx_d  = step_idx;
            if (step_changed) state_d = FETCH;
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      buf_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      start_q <= start_d;
      end_q   <= end_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign mem_rd_req = (state_q == FETCH) && !err_q;
  assign mem_addr   = word_q;
  assign byte_valid = (state_q == STREAM);
  assign byte_data  = buf_q[{idx_q, 3'b000} +: 8];
  assign busy       = (state_q == FETCH) || (state_q == STREAM);
  assign done       = (state_q == FINISH);

endmodule

// File: tb/tb_flash_byte_streamer.sv
// Scoreboard bench for flash_byte_streamer: directed streams with hand-computed bytes and addresses.
module tb_flash_byte_streamer;

  logic        clk, rst, start, stop, reverse, loop;
  logic [22:0] start_word, end_word, mem_addr;
  logic        mem_rd_req, mem_ack, byte_valid, byte_ready, busy, done;
  logic [31:0] mem_data;
  logic [7:0]  byte_data;

  flash_byte_streamer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .reverse(reverse), .loop(loop),
    .start_word(start_word), .end_word(end_word), .mem_rd_req(mem_rd_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_data(byte_data),
    .busy(busy), .done(done)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ack_delay = 0;
  int t0 = 0;
  logic [7:0]  exp_b[$];
  logic [22:0] exp_a[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    case (a)
      23'h10:  return 32'h44332211;
      23'h11:  return 32'h88776655;
      23'h05:  return 32'hDDCCBBAA;
      23'h20:  return 32'h04030201;
      23'h21:  return 32'h08070605;
      default: return 32'hDEAD0000 | {9'd0, a};
    endcase
  endfunction

  // Memory responder: acks after ack_delay FETCH cycles and checks the requested address.
  initial begin
    int wc;
    wc = 0;
    mem_ack  = 1'b0;
    mem_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        wc = 0;
      end else if (mem_rd_req) begin
        if (wc >= ack_delay) begin
          if (exp_a.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL mem_req_unexpected: got addr 0x%0h expected no request", mem_addr);
          end else begin
            chk("mem_addr", {9'd0, mem_addr}, {9'd0, exp_a.pop_front()});
          end
          mem_data = mem_word(mem_addr);
          mem_ack  = 1'b1;
          @(posedge clk);
          #1;
          mem_ack = 1'b0;
          wc = 0;
        end else begin
          wc++;
        end
      end
    end
  end

  // Byte monitor: every accepted byte is compared against the scoreboard queue.
  always @(negedge clk) begin
    if (!rst && byte_valid && byte_ready) begin
      if (exp_b.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL byte_unexpected: got 0x%0h expected no byte", byte_data);
      end else begin
        chk("byte", {24'd0, byte_data}, {24'd0, exp_b.pop_front()});
      end
    end
    if (!rst && done) done_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_stream(input logic [22:0] sw, input logic [22:0] ew, input logic rv,
                              input logic lp);
    start_word = sw; end_word = ew; reverse = rv; loop = lp;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim, output int rel);
    rel = -1;
    for (int i = 0; i < lim; i++) begin
      if (done) begin
        rel = cyc - t0;
        break;
      end
      tick();
    end
  endtask

  task automatic push_bytes(input logic [31:0] w0, input logic [31:0] w1, input int nb);
    logic [63:0] w;
    w = {w1, w0};
    for (int i = 0; i < nb; i++) exp_b.push_back(w[8*i +: 8]);
  endtask

  initial begin
    int rel, d0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; reverse = 1'b0; loop = 1'b0;
    start_word = '0; end_word = '0; byte_ready = 1'b1;
    tick(2);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_req", {31'd0, mem_rd_req}, 0);
    chk("rst_valid", {31'd0, byte_valid}, 0);
    chk("rst_data", {24'd0, byte_data}, 0);
    chk("rst_addr", {9'd0, mem_addr}, 0);
    rst = 1'b0;
    tick(2);

    // Forward 0x10..0x11
    exp_a.push_back(23'h10); exp_a.push_back(23'h11);
    push_bytes(32'h44332211, 32'h88776655, 8);
    d0 = done_cnt;
    begin_stream(23'h10, 23'h11, 1'b0, 1'b0);
    chk("fwd_busy", {31'd0, busy}, 1);
    chk("fwd_req", {31'd0, mem_rd_req}, 1);
    chk("fwd_addr", {9'd0, mem_addr}, 32'h10);
    wait_done(40, rel);
    chk("fwd_done_cyc", rel, 11);
    chk("fwd_busy_at_done", {31'd0, busy}, 0);
    tick();
    chk("fwd_done_pulse", {31'd0, done}, 0);
    chk("fwd_done_cnt", done_cnt - d0, 1);
    chk("fwd_bytes_left", exp_b.size(), 0);
    chk("fwd_addrs_left", exp_a.size(), 0);

    // Reverse, same range and data
    exp_a.push_back(23'h11); exp_a.push_back(23'h10);
    push_bytes(32'h55667788, 32'h11223344, 8);
    begin_stream(23'h10, 23'h11, 1'b1, 1'b0);
    chk("rev_addr", {9'd0, mem_addr}, 32'h11);
    wait_done(40, rel);
    chk("rev_done_cyc", rel, 11);
    tick();
    chk("rev_bytes_left", exp_b.size(), 0);
    chk("rev_addrs_left", exp_a.size(), 0);
    reverse = 1'b0;

    // Loop on a single word 0x5 until stop
    exp_a.push_back(23'h05); exp_a.push_back(23'h05);
    push_bytes(32'hDDCCBBAA, 32'h0000BBAA, 6);
    d0 = done_cnt;
    begin_stream(23'h05, 23'h05, 1'b0, 1'b1);
    tick(5);
    chk("loop_refetch_req", {31'd0, mem_rd_req}, 1);
    chk("loop_refetch_addr", {9'd0, mem_addr}, 32'h05);
    tick(2);
    chk("loop_no_done", done_cnt - d0, 0);
    chk("loop_busy", {31'd0, busy}, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("loop_done_after_stop", {31'd0, done}, 1);
    tick();
    chk("loop_done_cnt", done_cnt - d0, 1);
    chk("loop_bytes_left", exp_b.size(), 0);
    chk("loop_addrs_left", exp_a.size(), 0);
    loop = 1'b0;

    // Direction flip at index 2 of word 0x20
    exp_a.push_back(23'h20);
    push_bytes(32'h02030201, 32'h00000001, 5);
    begin_stream(23'h20, 23'h21, 1'b0, 1'b0);
    tick(3);
    reverse = 1'b1;
    wait_done(20, rel);
    chk("flip_done_cyc", rel, 7);
    tick();
    chk("flip_bytes_left", exp_b.size(), 0);
    chk("flip_addrs_left", exp_a.size(), 0);
    reverse = 1'b0;

    // Inverted range: no fetch, done two cycles after start
    begin_stream(23'h30, 23'h2F, 1'b0, 1'b0);
    chk("err_no_req", {31'd0, mem_rd_req}, 0);
    chk("err_busy", {31'd0, busy}, 1);
    wait_done(10, rel);
    chk("err_done_cyc", rel, 2);
    tick();

    // Backpressure: byte held while byte_ready is low
    byte_ready = 1'b0;
    exp_a.push_back(23'h10);
    push_bytes(32'h44332211, 32'h0, 4);
    begin_stream(23'h10, 23'h10, 1'b0, 1'b0);
    tick();
    chk("bp_valid0", {31'd0, byte_valid}, 1);
    chk("bp_data0", {24'd0, byte_data}, 32'h11);
    tick();
    chk("bp_valid1", {31'd0, byte_valid}, 1);
    chk("bp_data1", {24'd0, byte_data}, 32'h11);
    tick();
    byte_ready = 1'b1;
    wait_done(20, rel);
    chk("bp_done_cyc", rel, 8);
    tick();
    chk("bp_bytes_left", exp_b.size(), 0);

    // Abort during FETCH with ack delayed 5 cycles
    ack_delay = 5;
    exp_a.push_back(23'h40);
    begin_stream(23'h40, 23'h41, 1'b0, 1'b0);
    chk("abort_req_c1", {31'd0, mem_rd_req}, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int k = 2; k <= 6; k++) begin
      chk("abort_req_held", {31'd0, mem_rd_req}, 1);
      tick();
    end
    chk("abort_done", {31'd0, done}, 1);
    chk("abort_no_valid", {31'd0, byte_valid}, 0);
    tick();
    chk("abort_done_pulse", {31'd0, done}, 0);
    chk("abort_no_valid2", {31'd0, byte_valid}, 0);
    chk("abort_addrs_left", exp_a.size(), 0);
    ack_delay = 0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
